// File: rtl/morse_key_if.sv
// Key/character bus between the Morse key front end and the decoder.
// The master drives the key and clear, and the slave returns characters and pending-symbol status.
interface morse_key_if;
    logic       key_in;
    logic       clear;
    logic [7:0] char_out;
    logic       char_valid;
    logic [5:0] sym_bits;
    logic [2:0] sym_len;
    logic       busy;

    modport master (
        output key_in, clear,
        input  char_out, char_valid, sym_bits, sym_len, busy
    );

    modport slave (
        input  key_in, clear,
        output char_out, char_valid, sym_bits, sym_len, busy
    );
endinterface

// File: rtl/morse_key_decoder.sv
// Manual Morse key decoder: times presses and key-up gaps on the synchronized key,
// collects dot/dash symbols and emits one ASCII character (or a space) per letter/word.
module morse_key_decoder #(
    parameter int MIN_PRESS_CYC  = 10000,
    parameter int DOT_MAX_CYC    = 200000,
    parameter int LETTER_GAP_CYC = 400000,
    parameter int WORD_GAP_CYC   = 1000000,
    parameter int CNT_W          = 21
) (
    input  logic      clk,
    input  logic      rst,
    morse_key_if.slave key
);
    typedef enum logic [2:0] {IDLE, PRESS, GAP, WORD, WAIT_REL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] MIN_L      = CNT_W'(MIN_PRESS_CYC);
    localparam logic [CNT_W-1:0] DOT_L      = CNT_W'(DOT_MAX_CYC);
    localparam logic [CNT_W-1:0] LETTER_END = CNT_W'(LETTER_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] WORD_END   = CNT_W'(WORD_GAP_CYC - 1);

    state_t           state_reg, state_next;
    logic             key_meta_reg, key_s_reg;
    logic [CNT_W-1:0] press_cnt_reg, press_cnt_next;
    logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [5:0]       sym_bits_reg, sym_bits_next;
    logic [2:0]       sym_len_reg, sym_len_next;
    logic             overflow_reg, overflow_next;
    logic [7:0]       char_out_reg, char_out_next;
    logic             char_valid_reg, char_valid_next;
    logic [CNT_W-1:0] press_inc, gap_inc;

    // Symbols are appended LSB-first, so the first symbol of the letter sits in the highest used bit.
    function automatic logic [7:0] lookup(input logic [2:0] len, input logic [5:0] bits,
                                          input logic ovf);
        logic [7:0] c;
        c = 8'h3F;
        if (!ovf) begin
            case ({len, bits})
                {3'd2, 6'b000001}: c = 8'h41; // A .-
                {3'd4, 6'b001000}: c = 8'h42; // B -...
                {3'd4, 6'b001010}: c = 8'h43; // C -.-.
                {3'd3, 6'b000100}: c = 8'h44; // D -..
                {3'd1, 6'b000000}: c = 8'h45; // E .
                {3'd4, 6'b000010}: c = 8'h46; // F ..-.
                {3'd3, 6'b000110}: c = 8'h47; // G --.
                {3'd4, 6'b000000}: c = 8'h48; // H ....
                {3'd2, 6'b000000}: c = 8'h49; // I ..
                {3'd4, 6'b000111}: c = 8'h4A; // J .---
                {3'd3, 6'b000101}: c = 8'h4B; // K -.-
                {3'd4, 6'b000100}: c = 8'h4C; // L .-..
                {3'd2, 6'b000011}: c = 8'h4D; // M --
                {3'd2, 6'b000010}: c = 8'h4E; // N -.
                {3'd3, 6'b000111}: c = 8'h4F; // O ---
                {3'd4, 6'b000110}: c = 8'h50; // P .--.
                {3'd4, 6'b001101}: c = 8'h51; // Q --.-
                {3'd3, 6'b000010}: c = 8'h52; // R .-.
                {3'd3, 6'b000000}: c = 8'h53; // S ...
                {3'd1, 6'b000001}: c = 8'h54; // T -
                {3'd3, 6'b000001}: c = 8'h55; // U ..-
                {3'd4, 6'b000001}: c = 8'h56; // V ...-
                {3'd3, 6'b000011}: c = 8'h57; // W .--
                {3'd4, 6'b001001}: c = 8'h58; // X -..-
                {3'd4, 6'b001011}: c = 8'h59; // Y -.--
                {3'd4, 6'b001100}: c = 8'h5A; // Z --..
                {3'd5, 6'b011111}: c = 8'h30;
                {3'd5, 6'b001111}: c = 8'h31;
                {3'd5, 6'b000111}: c = 8'h32;
                {3'd5, 6'b000011}: c = 8'h33;
                {3'd5, 6'b000001}: c = 8'h34;
                {3'd5, 6'b000000}: c = 8'h35;
                {3'd5, 6'b010000}: c = 8'h36;
                {3'd5, 6'b011000}: c = 8'h37;
                {3'd5, 6'b011100}: c = 8'h38;
                {3'd5, 6'b011110}: c = 8'h39;
                default:           c = 8'h3F;
            endcase
        end
        return c;
    endfunction

    assign press_inc = (press_cnt_reg == CNT_MAX) ? press_cnt_reg : press_cnt_reg + 1'b1;
    assign gap_inc   = (gap_cnt_reg == CNT_MAX) ? gap_cnt_reg : gap_cnt_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        press_cnt_next  = press_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        sym_bits_next   = sym_bits_reg;
        sym_len_next    = sym_len_reg;
        overflow_next   = overflow_reg;
        char_out_next   = char_out_reg;
        char_valid_next = 1'b0;

        if (key.clear) begin
            sym_bits_next = '0;
            sym_len_next  = '0;
            overflow_next = 1'b0;
            state_next    = key_s_reg ? WAIT_REL : IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_s_reg) begin
                        state_next     = PRESS;
                        press_cnt_next = '0;
                    end
                end
                PRESS: begin
                    if (key_s_reg) begin
                        press_cnt_next = press_inc;
                    end else begin
                        gap_cnt_next = '0;
                        if (press_cnt_reg < MIN_L) begin
                            state_next = (sym_len_reg != 3'd0) ? GAP : IDLE;
                        end else begin
                            state_next = GAP;
                            if (sym_len_reg == 3'd6) begin
                                overflow_next = 1'b1;
                            end else begin
                                sym_bits_next = {sym_bits_reg[4:0], press_cnt_reg >= DOT_L};
                                sym_len_next  = sym_len_reg + 3'd1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (key_s_reg) begin
                        state_next     = PRESS;
                        press_cnt_next = '0;
                    end else begin
                        gap_cnt_next = gap_inc;
                        if (gap_cnt_reg == LETTER_END) begin
                            char_valid_next = 1'b1;
                            char_out_next   = lookup(sym_len_reg, sym_bits_reg, overflow_reg);
                            sym_bits_next   = '0;
                            sym_len_next    = '0;
                            overflow_next   = 1'b0;
                            state_next      = WORD;
                        end
                    end
                end
                WORD: begin
                    if (key_s_reg) begin
                        state_next     = PRESS;
                        press_cnt_next = '0;
                    end else begin
                        gap_cnt_next = gap_inc;
                        if (gap_cnt_reg == WORD_END) begin
                            char_valid_next = 1'b1;
                            char_out_next   = 8'h20;
                            state_next      = IDLE;
                        end
                    end
                end
                WAIT_REL: begin
                    if (!key_s_reg) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_reg   <= 1'b0;
            key_s_reg      <= 1'b0;
            state_reg      <= IDLE;
            press_cnt_reg  <= '0;
            gap_cnt_reg    <= '0;
            sym_bits_reg   <= '0;
            sym_len_reg    <= '0;
            overflow_reg   <= 1'b0;
            char_out_reg   <= 8'h00;
            char_valid_reg <= 1'b0;
        end else begin
            key_meta_reg   <= key.key_in;
            key_s_reg      <= key_meta_reg;
            state_reg      <= state_next;
            press_cnt_reg  <= press_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            sym_bits_reg   <= sym_bits_next;
            sym_len_reg    <= sym_len_next;
            overflow_reg   <= overflow_next;
            char_out_reg   <= char_out_next;
            char_valid_reg <= char_valid_next;
        end
    end

    assign key.char_out   = char_out_reg;
    assign key.char_valid = char_valid_reg;
    assign key.sym_bits   = sym_bits_reg;
    assign key.sym_len    = sym_len_reg;
    assign key.busy       = (state_reg != IDLE);
endmodule
